// File: rtl/io_port_channel_if.sv
// Port-pair bus between the MMIO controller side and the stream side of io_port_channel.
// Streams use valid/ready: a word moves on a clock edge where both are high, and
// the source holds valid and data stable until that happens.
interface io_port_channel_if;
  logic        inform_write;
  logic        inform_read;
  logic [15:0] port_data_in;
  logic [15:0] port_cmd_in;
  logic [15:0] port_data_out;
  logic [15:0] port_status_out;
  logic        tx_valid;
  logic [15:0] tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [15:0] rx_data;
  logic        rx_ready;

  modport slave (
    input  inform_write, inform_read, port_data_in, port_cmd_in,
    output port_data_out, port_status_out,
    output tx_valid, tx_data,
    input  tx_ready,
    input  rx_valid, rx_data,
    output rx_ready
  );

  modport master (
    output inform_write, inform_read, port_data_in, port_cmd_in,
    input  port_data_out, port_status_out,
    input  tx_valid, tx_data,
    output tx_ready,
    output rx_valid, rx_data,
    input  rx_ready
  );
endinterface

// File: rtl/io_port_channel.sv
// Peripheral endpoint for one MMIO port pair: TX FIFO fed by port writes and drained
// to a stream, RX FIFO filled from a stream and popped by port reads.
module io_port_channel #(
  parameter int DEPTH = 8
) (
  input logic clk,
  input logic rst_n,
  io_port_channel_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic             write_prev, read_prev;
  logic [15:0]      tx_mem [DEPTH];
  logic [15:0]      rx_mem [DEPTH];
  logic [PTR_W-1:0] tx_rd_ptr, tx_wr_ptr, rx_rd_ptr, rx_wr_ptr;
  logic [CNT_W-1:0] tx_count, rx_count;
  logic             tx_ovf, rx_ovf;

  // One event per strobe assertion, however long the controller holds it.
  logic write_evt, read_evt;
  assign write_evt = bus.inform_write & ~write_prev;
  assign read_evt  = bus.inform_read & ~read_prev;

  logic cmd_push, cmd_tx_flush, cmd_rx_flush, cmd_clr_err;
  assign cmd_push     = write_evt & bus.port_cmd_in[0];
  assign cmd_tx_flush = write_evt & bus.port_cmd_in[1];
  assign cmd_rx_flush = write_evt & bus.port_cmd_in[2];
  assign cmd_clr_err  = write_evt & bus.port_cmd_in[3];

  logic tx_full, tx_empty, rx_full, rx_empty;
  assign tx_full  = (tx_count == FULL_CNT);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == FULL_CNT);
  assign rx_empty = (rx_count == '0);

  // A stream pop frees the slot before a same-cycle push needs it; flushes override both.
  logic tx_pop, tx_push, tx_ovf_set;
  assign tx_pop     = ~tx_empty & bus.tx_ready;
  assign tx_push    = cmd_push & (~tx_full | tx_pop) & ~cmd_tx_flush;
  assign tx_ovf_set = cmd_push & tx_full & ~tx_pop & ~cmd_tx_flush;

  logic rx_push, rx_pop, rx_ovf_set;
  assign rx_push    = bus.rx_valid & ~rx_full & ~cmd_rx_flush;
  assign rx_pop     = read_evt & ~rx_empty & ~cmd_rx_flush;
  assign rx_ovf_set = bus.rx_valid & rx_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_prev <= 1'b0;
      read_prev  <= 1'b0;
    end else begin
      write_prev <= bus.inform_write;
      read_prev  <= bus.inform_read;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_rd_ptr <= '0;
      tx_wr_ptr <= '0;
      tx_count  <= '0;
    end else if (cmd_tx_flush) begin
      tx_rd_ptr <= '0;
      tx_wr_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_count  <= '0;
    end else if (cmd_rx_flush) begin
      rx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  // A new error in the same event as CLR_ERR stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ovf <= 1'b0;
      rx_ovf <= 1'b0;
    end else begin
      if (tx_ovf_set)       tx_ovf <= 1'b1;
      else if (cmd_clr_err) tx_ovf <= 1'b0;
      if (rx_ovf_set)       rx_ovf <= 1'b1;
      else if (cmd_clr_err) rx_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.port_data_in;
    if (rx_push) rx_mem[rx_wr_ptr] <= bus.rx_data;
  end

  assign bus.tx_valid        = ~tx_empty;
  assign bus.tx_data         = tx_empty ? 16'h0000 : tx_mem[tx_rd_ptr];
  assign bus.rx_ready        = ~rx_full;
  assign bus.port_data_out   = rx_empty ? 16'h0000 : rx_mem[rx_rd_ptr];
  assign bus.port_status_out = {8'(rx_count), 2'b00, rx_ovf, tx_ovf,
                                rx_full, rx_empty, tx_empty, tx_full};
endmodule

// File: tb/tb_io_port_channel.sv
// Directed bench for io_port_channel: stimulus queues expected observations, a negedge
// monitor pops them and also checks every TX stream word against the expected order.
module tb_io_port_channel;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  io_port_channel_if bus ();
  io_port_channel #(.DEPTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int tests = 0;
  int fails = 0;

  logic [15:0] tx_exp_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] mask_q[$];
  logic [1:0]  sel_q[$];
  string       name_q[$];

  function automatic logic [15:0] observe(input logic [1:0] sel);
    case (sel)
      2'd0:    return bus.port_status_out;
      2'd1:    return bus.port_data_out;
      2'd2:    return bus.tx_data;
      default: return {14'b0, bus.rx_ready, bus.tx_valid};
    endcase
  endfunction

  // sel: 0 status, 1 port_data_out, 2 tx_data, 3 {rx_ready, tx_valid}
  task automatic expect_obs(input string name, input logic [1:0] sel,
                            input logic [15:0] mask, input logic [15:0] val);
    name_q.push_back(name);
    sel_q.push_back(sel);
    mask_q.push_back(mask);
    exp_q.push_back(val);
  endtask

  always @(negedge clk) begin
    if (bus.tx_valid && bus.tx_ready) begin
      tests++;
      if (tx_exp_q.size() == 0) begin
        fails++;
        $display("FAIL tx_unexpected: got %h, required no handshake", bus.tx_data);
      end else begin
        logic [15:0] e;
        e = tx_exp_q.pop_front();
        if (bus.tx_data !== e) begin
          fails++;
          $display("FAIL tx_stream: got %h, required %h", bus.tx_data, e);
        end
      end
    end
    while (exp_q.size() > 0) begin
      logic [15:0] e, m, a;
      logic [1:0]  s;
      string       n;
      e = exp_q.pop_front();
      m = mask_q.pop_front();
      s = sel_q.pop_front();
      n = name_q.pop_front();
      a = observe(s) & m;
      tests++;
      if (a !== (e & m)) begin
        fails++;
        $display("FAIL %s: got %h, required %h (mask %h)", n, a, e & m, m);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_evt(input logic [15:0] cmd, input logic [15:0] data);
    bus.port_cmd_in  = cmd;
    bus.port_data_in = data;
    bus.inform_write = 1'b1;
    tick();
    bus.inform_write = 1'b0;
    tick();
  endtask

  task automatic read_evt();
    bus.inform_read = 1'b1;
    tick();
    bus.inform_read = 1'b0;
    tick();
  endtask

  task automatic rx_send(input logic [15:0] word);
    bus.rx_valid = 1'b1;
    bus.rx_data  = word;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    bus.tx_ready = 1'b1;
    repeat (n) tick();
    bus.tx_ready = 1'b0;
  endtask

  initial begin
    bus.inform_write = 1'b0;
    bus.inform_read  = 1'b0;
    bus.port_data_in = '0;
    bus.port_cmd_in  = '0;
    bus.tx_ready     = 1'b0;
    bus.rx_valid     = 1'b0;
    bus.rx_data      = '0;

    // Reset values
    tick();
    expect_obs("rst_status", 0, 16'hFFFF, 16'h0006);
    expect_obs("rst_data_out", 1, 16'hFFFF, 16'h0000);
    expect_obs("rst_tx_data", 2, 16'hFFFF, 16'h0000);
    expect_obs("rst_flags", 3, 16'h0003, 16'h0002);
    tick();
    rst_n = 1'b1;
    tick();

    // Push and drain one word
    write_evt(16'h0001, 16'hA5A5);
    expect_obs("push_tx_data", 2, 16'hFFFF, 16'hA5A5);
    expect_obs("push_flags", 3, 16'h0003, 16'h0003);
    expect_obs("push_tx_empty", 0, 16'h0002, 16'h0000);
    tx_exp_q.push_back(16'hA5A5);
    drain(1);
    expect_obs("drain_flags", 3, 16'h0003, 16'h0002);
    expect_obs("drain_status", 0, 16'hFFFF, 16'h0006);
    tick();

    // TX overflow: ninth word dropped
    for (int i = 1; i <= 9; i++) write_evt(16'h0001, 16'(i));
    expect_obs("ovf_status", 0, 16'h0013, 16'h0011);
    tick();
    for (int i = 1; i <= 8; i++) tx_exp_q.push_back(16'(i));
    drain(8);
    expect_obs("ovf_drained", 3, 16'h0001, 16'h0000);
    expect_obs("ovf_sticky", 0, 16'h0010, 16'h0010);
    tick();
    write_evt(16'h0008, 16'h0000);
    expect_obs("clr_tx_ovf", 0, 16'h0010, 16'h0000);
    tick();

    // Held write strobe gives one push
    bus.port_cmd_in  = 16'h0001;
    bus.port_data_in = 16'h0BEE;
    bus.inform_write = 1'b1;
    repeat (5) tick();
    bus.inform_write = 1'b0;
    tick();
    tx_exp_q.push_back(16'h0BEE);
    drain(1);
    expect_obs("held_write_one", 3, 16'h0001, 16'h0000);
    tick();

    // Held read strobe gives one pop
    rx_send(16'h0101);
    rx_send(16'h0202);
    bus.inform_read = 1'b1;
    repeat (4) tick();
    bus.inform_read = 1'b0;
    tick();
    expect_obs("held_read_cnt", 0, 16'hFF00, 16'h0100);
    expect_obs("held_read_head", 1, 16'hFFFF, 16'h0202);
    read_evt();

    // RX fill and read
    rx_send(16'h1111);
    rx_send(16'h2222);
    tick();
    expect_obs("rx_head0", 1, 16'hFFFF, 16'h1111);
    expect_obs("rx_cnt2", 0, 16'hFF04, 16'h0200);
    read_evt();
    expect_obs("rx_head1", 1, 16'hFFFF, 16'h2222);
    read_evt();
    expect_obs("rx_empty_data", 1, 16'hFFFF, 16'h0000);
    expect_obs("rx_empty_flag", 0, 16'hFF04, 16'h0004);
    read_evt();
    expect_obs("rx_extra_read", 0, 16'hFFFF, 16'h0006);

    // RX full, held word accepted after a pop
    for (int i = 0; i < 8; i++) rx_send(16'h3000 + 16'(i));
    bus.rx_valid = 1'b1;
    bus.rx_data  = 16'h3008;
    tick();
    expect_obs("rx_full_flags", 3, 16'h0003, 16'h0000);
    expect_obs("rx_full_status", 0, 16'hFF2C, 16'h0828);
    bus.inform_read = 1'b1;
    tick();
    expect_obs("rx_ready_after_pop", 3, 16'h0002, 16'h0002);
    bus.inform_read = 1'b0;
    tick();
    bus.rx_valid = 1'b0;
    expect_obs("rx_refill_cnt", 0, 16'hFF00, 16'h0800);
    expect_obs("rx_refill_head", 1, 16'hFFFF, 16'h3001);
    for (int i = 0; i < 7; i++) read_evt();
    expect_obs("rx_entry8", 1, 16'hFFFF, 16'h3008);
    read_evt();
    write_evt(16'h0008, 16'h0000);
    expect_obs("clr_rx_ovf", 0, 16'hFFFF, 16'h0006);

    // TX full with simultaneous push and handshake
    for (int i = 0; i < 8; i++) write_evt(16'h0001, 16'h0040 + 16'(i));
    tx_exp_q.push_back(16'h0040);
    bus.port_cmd_in  = 16'h0001;
    bus.port_data_in = 16'h0048;
    bus.inform_write = 1'b1;
    bus.tx_ready     = 1'b1;
    tick();
    bus.inform_write = 1'b0;
    bus.tx_ready     = 1'b0;
    tick();
    expect_obs("full_pushpop", 0, 16'h0013, 16'h0001);
    tick();
    for (int i = 1; i <= 8; i++) tx_exp_q.push_back(16'h0040 + 16'(i));
    drain(8);
    expect_obs("full_pushpop_drained", 3, 16'h0001, 16'h0000);
    tick();

    // Push plus RX flush in one event
    rx_send(16'h0A01);
    rx_send(16'h0A02);
    rx_send(16'h0A03);
    write_evt(16'h0005, 16'h0055);
    expect_obs("flush_status", 0, 16'hFF06, 16'h0004);
    expect_obs("flush_data_out", 1, 16'hFFFF, 16'h0000);
    expect_obs("flush_tx_data", 2, 16'hFFFF, 16'h0055);
    tick();

    // Asynchronous reset mid-drain
    write_evt(16'h0001, 16'h0066);
    write_evt(16'h0001, 16'h0077);
    tx_exp_q.push_back(16'h0055);
    bus.tx_ready = 1'b1;
    tick();
    #1 rst_n = 1'b0;
    expect_obs("arst_status", 0, 16'hFFFF, 16'h0006);
    expect_obs("arst_flags", 3, 16'h0003, 16'h0002);
    expect_obs("arst_tx_data", 2, 16'hFFFF, 16'h0000);
    expect_obs("arst_data_out", 1, 16'hFFFF, 16'h0000);
    @(negedge clk);
    #1;
    bus.tx_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    tests++;
    if (tx_exp_q.size() != 0) begin
      fails++;
      $display("FAIL tx_leftover: got %0d pending words, required 0", tx_exp_q.size());
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL obs_leftover: got %0d pending checks, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/io_port_channel.md
Name: io_port_channel

Overview:
- Peripheral-side endpoint for one MMIO port pair (even word = data, odd word = command/status). Sits directly downstream of the MMIO controller.
- Consumes the controller's per-port write strobe and the two latched output words, and buffers outgoing data in a TX FIFO that drains to an external valid/ready stream.
- Buffers incoming stream data in an RX FIFO. Drives the two port input words that the controller returns on CPU reads, and pops RX on the read strobe.

Parameters:
- DEPTH, 8, entries per FIFO (TX and RX each); power of two, 2..128.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- inform_write  in  1  port write strobe from the MMIO controller; level, may stay high across cycles.
- inform_read  in  1  port read strobe from the MMIO controller; level, may stay high across cycles.
- port_data_in  in  16  even port word from the controller (TX data).
- port_cmd_in  in  16  odd port word from the controller (command).
- port_data_out  out  16  even port word to the controller: RX FIFO head, 0 when empty.
- port_status_out  out  16  odd port word to the controller: status.
- tx_valid  out  1  TX stream valid.
- tx_data  out  16  TX stream data (TX head).
- tx_ready  in  1  TX stream ready.
- rx_valid  in  1  RX stream valid.
- rx_data  in  16  RX stream data.
- rx_ready  out  1  RX stream ready.

Behaviour:
- Reset (async assert, sync-safe deassert): both FIFOs empty, pointers and counts 0, sticky flags 0, strobe edge registers 0.
  - Output values in reset: tx_valid=0, tx_data=0, rx_ready=1, port_data_out=0, port_status_out=16'h0006.
- Strobe detection: inform_write and inform_read are registered once. An event is the rising edge (cur & ~prev), giving one event per assertion regardless of hold length.
  - Event sampling is cycle N; the effect is visible on outputs at cycle N+1.
- Write event: decode port_cmd_in sampled in the event cycle.
  - bit0 PUSH: push port_data_in to TX. If TX is full, drop the data and set tx_ovf.
  - bit1 TX_FLUSH: empty TX.
  - bit2 RX_FLUSH: empty RX.
  - bit3 CLR_ERR: clear tx_ovf and rx_ovf.
  - Other bits are ignored. Multiple bits are legal.
  - Flush beats push in the same event (the data is dropped, no overflow is flagged).
- Read event: pop the RX head if RX is non-empty. On empty, no-op (no underflow flag).
- TX stream: tx_valid = (tx_count != 0), and tx_data = head. A handshake (tx_valid & tx_ready) pops TX.
  - A pop and a push in the same cycle are both accepted: count is unchanged, even when TX is full, because the pop frees the slot first.
  - A handshake in the same cycle as TX_FLUSH is discarded; the flush wins.
- RX stream: rx_ready = (rx_count != DEPTH), computed from registered count only, with no combinational path from inform_read.
  - A handshake pushes rx_data.
  - rx_ovf is set when rx_valid is high while rx_ready is low. The word is not accepted; the source holds it.
  - Simultaneous push and read-pop: both occur.
  - Simultaneous push and RX_FLUSH: the flush wins and the pushed word is lost.
- Status word layout:
  - [0] tx_full
  - [1] tx_empty
  - [2] rx_empty
  - [3] rx_full
  - [4] tx_ovf
  - [5] rx_ovf
  - [7:6] 0
  - [15:8] rx_count, zero-extended
- port_data_out and port_status_out are driven combinationally from registered state only.
- Pointers wrap modulo DEPTH. Count saturates by construction (0..DEPTH).

Test Plan:
- Reset, then push-and-drain: reset, then write event with cmd=16'h0001, data=16'hA5A5, with tx_ready=0.
  - Next cycle: tx_valid=1, tx_data=16'hA5A5, status[1]=0.
  - Then tx_ready=1 for one cycle: tx_valid=0, status=16'h0006.
- TX overflow: 9 write events with cmd=1 and data 1..9, tx_ready=0, DEPTH=8.
  - Required: status[0]=1, status[4]=1.
  - Draining yields exactly 1..8 in order.
  - A write event with cmd=16'h0008 then clears bit4.
- Held strobe: hold inform_write high for 5 cycles with cmd=1.
  - Required: exactly one TX entry.
  - Hold inform_read high for 4 cycles with RX holding 2 words: exactly one pop.
- RX fill and read: push 16'h1111, 16'h2222 via rx stream.
  - Required: port_data_out=16'h1111, status[15:8]=2.
  - After a read event: port_data_out=16'h2222.
  - After a second read: port_data_out=0, status[2]=1.
  - A third read has no effect.
- RX full: push 8 words, then hold rx_valid=1.
  - Required: rx_ready=0 and status[5]=1.
  - A read event pops one word; the next cycle rx_ready=1, and the held word is accepted as entry 8.
- Simultaneous ops and async reset:
  - TX full plus push and tx handshake in the same cycle: count stays at 8, order preserved.
  - Write event cmd=16'h0005 while RX holds 3 words: RX is empty and the TX push is accepted.
  - rst_n asserted mid-drain: all outputs take their reset values immediately, without waiting for a clock edge.
